// File: rtl/icache_ctrl.sv
// 2-way, 64-set, 128-bit-line read-only instruction cache controller.
// Handles lookup, hit return, 4-beat refill with LRU victim choice, and full flush.
module icache_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_req_i,
    output logic         cpu_gnt_o,
    input  logic [31:0]  cpu_addr_i,
    output logic         cpu_rvalid_o,
    output logic [31:0]  cpu_rdata_o,
    input  logic         flush_i,
    output logic         flush_busy_o,
    output logic         mem_req_o,
    input  logic         mem_gnt_i,
    output logic [31:0]  mem_addr_o,
    input  logic         mem_rvalid_i,
    input  logic [31:0]  mem_rdata_i,
    output logic [5:0]   cm_set_o,
    output logic         cm_way_o,
    output logic         cm_enable_o,
    output logic         cm_write_enable_o,
    output logic         cm_val_write_enable_o,
    output logic         cm_line_valid_o,
    output logic [21:0]  cm_line_tag_o,
    output logic [127:0] cm_line_o,
    output logic [15:0]  cm_line_be_o,
    input  logic [1:0]   cm_line_valid_i,
    input  logic [43:0]  cm_line_tag_i,
    input  logic [127:0] cm_line_i
);

    localparam int unsigned TAG_W  = 22;
    localparam int unsigned SET_W  = 6;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned NSETS  = 64;
    localparam int unsigned FCNT_W = 7;

    typedef enum logic [2:0] {
        S_IDLE, S_TAG, S_DATA, S_REFILL, S_FILL_WR, S_RESP, S_FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic [29:0]         addr_q, addr_d;     // fetch address without byte offset
    logic                victim_q, victim_d;
    logic [1:0]          beat_q, beat_d;
    logic                sent_q, sent_d;     // current beat granted, awaiting data
    logic [LINE_W-1:0]   buf_q, buf_d;
    logic [NSETS-1:0]    lru_q, lru_d;       // way to evict next, per set
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [TAG_W-1:0]    tag_c;
    logic [SET_W-1:0]    set_c;
    logic [1:0]          word_c;
    logic [1:0]          hit_c;
    logic                beat_fire_c;
    logic                unused_addr_c;

    assign tag_c  = addr_q[29:8];
    assign set_c  = addr_q[7:2];
    assign word_c = addr_q[1:0];
    assign hit_c[0] = cm_line_valid_i[0] && (cm_line_tag_i[TAG_W-1:0] == tag_c);
    assign hit_c[1] = cm_line_valid_i[1] && (cm_line_tag_i[2*TAG_W-1:TAG_W] == tag_c);
    // Data may arrive in the grant cycle or any later cycle.
    assign beat_fire_c   = mem_rvalid_i && (sent_q || (mem_req_o && mem_gnt_i));
    assign unused_addr_c = ^cpu_addr_i[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            victim_q <= 1'b0;
            beat_q   <= '0;
            sent_q   <= 1'b0;
            buf_q    <= '0;
            lru_q    <= '0;
            fcnt_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            victim_q <= victim_d;
            beat_q   <= beat_d;
            sent_q   <= sent_d;
            buf_q    <= buf_d;
            lru_q    <= lru_d;
            fcnt_q   <= fcnt_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next state and datapath updates.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        victim_d = victim_q;
        beat_d   = beat_q;
        sent_d   = sent_q;
        buf_d    = buf_q;
        lru_d    = lru_q;
        fcnt_d   = fcnt_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    state_d = S_FLUSH;
                end else if (cpu_req_i) begin
                    addr_d  = cpu_addr_i[31:2];
                    state_d = S_TAG;
                end
            end
            S_TAG: begin
                if (|hit_c) begin
                    lru_d[set_c] = hit_c[0];
                    state_d      = S_DATA;
                end else begin
                    if (!cm_line_valid_i[0])      victim_d = 1'b0;
                    else if (!cm_line_valid_i[1]) victim_d = 1'b1;
                    else                          victim_d = lru_q[set_c];
                    beat_d  = '0;
                    sent_d  = 1'b0;
                    state_d = S_REFILL;
                end
            end
            S_DATA: begin
                rdata_d = cm_line_i[{word_c, 5'b0} +: 32];
                state_d = S_RESP;
            end
            S_REFILL: begin
                if (mem_req_o && mem_gnt_i) sent_d = 1'b1;
                if (beat_fire_c) begin
                    buf_d[{beat_q, 5'b0} +: 32] = mem_rdata_i;
                    sent_d = 1'b0;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) state_d = S_FILL_WR;
                end
            end
            S_FILL_WR: begin
                lru_d[set_c] = ~victim_q;
                rdata_d      = buf_q[{word_c, 5'b0} +: 32];
                state_d      = S_RESP;
            end
            S_RESP: state_d = S_IDLE;
            S_FLUSH: begin
                fcnt_d = fcnt_q + FCNT_W'(1);
                lru_d  = '0;
                if (fcnt_q == FCNT_W'(127)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; only the IDLE enable looks at the request.
    always_comb begin
        cpu_gnt_o             = !reset && (state_q == S_IDLE) && !flush_i;
        cpu_rvalid_o          = 1'b0;
        cpu_rdata_o           = '0;
        flush_busy_o          = 1'b0;
        mem_req_o             = 1'b0;
        mem_addr_o            = '0;
        cm_set_o              = '0;
        cm_way_o              = 1'b0;
        cm_enable_o           = 1'b0;
        cm_write_enable_o     = 1'b0;
        cm_val_write_enable_o = 1'b0;
        cm_line_valid_o       = 1'b0;
        cm_line_tag_o         = '0;
        cm_line_o             = '0;
        cm_line_be_o          = 16'hFFFF;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_gnt_o && cpu_req_i) begin
                    cm_enable_o = 1'b1;
                    cm_set_o    = cpu_addr_i[9:4];
                end
            end
            S_TAG: begin
                if (|hit_c) begin
                    cm_enable_o = 1'b1;
                    cm_set_o    = set_c;
                    cm_way_o    = !hit_c[0];
                end
            end
            S_REFILL: begin
                mem_req_o  = !sent_q;
                mem_addr_o = {addr_q[29:2], beat_q, 2'b00};
            end
            S_FILL_WR: begin
                cm_enable_o           = 1'b1;
                cm_write_enable_o     = 1'b1;
                cm_val_write_enable_o = 1'b1;
                cm_line_valid_o       = 1'b1;
                cm_set_o              = set_c;
                cm_way_o              = victim_q;
                cm_line_tag_o         = tag_c;
                cm_line_o             = buf_q;
            end
            S_RESP: begin
                cpu_rvalid_o = 1'b1;
                cpu_rdata_o  = rdata_q;
            end
            S_FLUSH: begin
                flush_busy_o          = 1'b1;
                cm_enable_o           = 1'b1;
                cm_val_write_enable_o = 1'b1;
                cm_set_o              = fcnt_q[6:1];
                cm_way_o              = fcnt_q[0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: cache_mem_wrap and memory-bus models, directed fetches,
// and a queue-based scoreboard checked by an independent monitor.
module tb_icache_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req_i, cpu_gnt_o;
    logic [31:0]  cpu_addr_i;
    logic         cpu_rvalid_o;
    logic [31:0]  cpu_rdata_o;
    logic         flush_i, flush_busy_o;
    logic         mem_req_o, mem_gnt_i;
    logic [31:0]  mem_addr_o;
    logic         mem_rvalid_i;
    logic [31:0]  mem_rdata_i;
    logic [5:0]   cm_set_o;
    logic         cm_way_o, cm_enable_o, cm_write_enable_o, cm_val_write_enable_o, cm_line_valid_o;
    logic [21:0]  cm_line_tag_o;
    logic [127:0] cm_line_o;
    logic [15:0]  cm_line_be_o;
    logic [1:0]   cm_line_valid_i;
    logic [43:0]  cm_line_tag_i;
    logic [127:0] cm_line_i;

    icache_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_req_i(cpu_req_i), .cpu_gnt_o(cpu_gnt_o), .cpu_addr_i(cpu_addr_i),
        .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .flush_i(flush_i), .flush_busy_o(flush_busy_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .cm_set_o(cm_set_o), .cm_way_o(cm_way_o), .cm_enable_o(cm_enable_o),
        .cm_write_enable_o(cm_write_enable_o), .cm_val_write_enable_o(cm_val_write_enable_o),
        .cm_line_valid_o(cm_line_valid_o), .cm_line_tag_o(cm_line_tag_o),
        .cm_line_o(cm_line_o), .cm_line_be_o(cm_line_be_o),
        .cm_line_valid_i(cm_line_valid_i), .cm_line_tag_i(cm_line_tag_i), .cm_line_i(cm_line_i)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int busy_cnt = 0, fwr_cnt = 0, req_cyc = 0, rv_cnt = 0;
    int gnt_stall = 0;
    logic [31:0] mem_salt = '0;
    logic        model_clr;

    logic [31:0]  rsp_data_q[$];
    int           rsp_due_q[$];
    logic [31:0]  exp_addr_q[$];
    logic [158:0] fill_q[$];

    localparam logic [244:0] RST_OUTS = {229'd0, 16'hFFFF};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [244:0] outs();
        return {cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, flush_busy_o, mem_req_o, mem_addr_o,
                cm_set_o, cm_way_o, cm_enable_o, cm_write_enable_o, cm_val_write_enable_o,
                cm_line_valid_o, cm_line_tag_o, cm_line_o, cm_line_be_o};
    endfunction

    function automatic logic [31:0] mem_word(input logic [1:0] b, input logic [31:0] s);
        return (32'h1111_1111 * (32'(b) + 32'd1)) ^ s;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // cache_mem_wrap model: one-cycle read latency, writes on enable.
    logic         cmv [2][64];
    logic [21:0]  cmt [2][64];
    logic [127:0] cmd [2][64];
    always @(posedge clk) begin
        if (model_clr) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < 64; s++) cmv[w][s] <= 1'b0;
        end else if (cm_enable_o) begin
            if (cm_val_write_enable_o) cmv[cm_way_o][cm_set_o] <= cm_line_valid_o;
            if (cm_write_enable_o) begin
                cmt[cm_way_o][cm_set_o] <= cm_line_tag_o;
                cmd[cm_way_o][cm_set_o] <= cm_line_o;
            end
            cm_line_valid_i <= {cmv[1][cm_set_o], cmv[0][cm_set_o]};
            cm_line_tag_i   <= {cmt[1][cm_set_o], cmt[0][cm_set_o]};
            cm_line_i       <= cmd[cm_way_o][cm_set_o];
        end
    end

    // Memory bus model: optional grant stall, data one cycle after each grant.
    initial begin
        logic        hs_pend;
        logic [31:0] hs_addr;
        hs_pend = 1'b0;
        hs_addr = '0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_rvalid_i = hs_pend;
            mem_rdata_i  = hs_pend ? mem_word(hs_addr[3:2], mem_salt) : 32'd0;
            if (hs_pend) rv_cnt++;
            if (gnt_stall > 0 && mem_req_o) begin
                mem_gnt_i = 1'b0;
                gnt_stall--;
            end else begin
                mem_gnt_i = 1'b1;
            end
            hs_pend = mem_req_o && mem_gnt_i;
            hs_addr = mem_addr_o;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response or transfer.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_addr;
        logic [6:0]  flush_idx;
        prev_stall = 1'b0;
        prev_addr  = '0;
        flush_idx  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (cpu_rvalid_o) begin
                check("rsp_expected", 256'(rsp_data_q.size() > 0), 256'(1));
                if (rsp_data_q.size() > 0) begin
                    int due;
                    check("rdata", 256'(cpu_rdata_o), 256'(rsp_data_q.pop_front()));
                    due = rsp_due_q.pop_front();
                    if (due >= 0) check("hit_latency", 256'(cyc), 256'(due));
                end
            end
            if (mem_req_o && mem_gnt_i) begin
                check("mem_beat_expected", 256'(exp_addr_q.size() > 0), 256'(1));
                if (exp_addr_q.size() > 0)
                    check("mem_addr", 256'(mem_addr_o), 256'(exp_addr_q.pop_front()));
            end
            if (prev_stall)
                check("mem_hold_stable", 256'({mem_req_o, mem_addr_o}), 256'({1'b1, prev_addr}));
            prev_stall = mem_req_o && !mem_gnt_i;
            prev_addr  = mem_addr_o;
            if (mem_req_o) req_cyc++;
            if (cm_enable_o && cm_write_enable_o) begin
                check("fill_expected", 256'(fill_q.size() > 0), 256'(1));
                if (fill_q.size() > 0)
                    check("fill_write", 256'({cm_val_write_enable_o, cm_line_valid_o, cm_set_o,
                          cm_way_o, cm_line_tag_o, cm_line_o}), 256'(fill_q.pop_front()));
            end
            if (!flush_busy_o) flush_idx = '0;
            else busy_cnt++;
            if (cm_enable_o && cm_val_write_enable_o && !cm_write_enable_o) begin
                check("flush_write", 256'({cm_set_o, cm_way_o, cm_line_valid_o, flush_busy_o, cpu_gnt_o}),
                      256'({flush_idx, 1'b0, 1'b1, 1'b0}));
                flush_idx++;
                fwr_cnt++;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] salt, input bit miss,
                         input logic way, input logic [31:0] exp_rd);
        int r0;
        logic [127:0] line;
        @(negedge clk);
        mem_salt = salt;
        if (miss) begin
            for (int b = 0; b < 4; b++) begin
                exp_addr_q.push_back({a[31:4], 2'(b), 2'b00});
                line[b*32 +: 32] = mem_word(2'(b), salt);
            end
            fill_q.push_back({2'b11, a[9:4], way, a[31:10], line});
        end
        rsp_data_q.push_back(exp_rd);
        rsp_due_q.push_back(miss ? -1 : cyc + 3);
        r0 = req_cyc;
        cpu_req_i  = 1'b1;
        cpu_addr_i = a;
        #1;
        check("cpu_gnt", 256'(cpu_gnt_o), 256'(1));
        @(negedge clk);
        cpu_req_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rsp_data_q.size() == 0) break;
            @(negedge clk);
        end
        check("rsp_drained", 256'(rsp_data_q.size()), 256'(0));
        if (!miss) check("hit_no_mem_req", 256'(req_cyc - r0), 256'(0));
        rsp_data_q.delete();
        rsp_due_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, w0, r0;
        reset      = 1'b1;
        model_clr  = 1'b1;
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_0414;
        flush_i    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 256'(outs()), 256'(RST_OUTS));
        cpu_req_i = 1'b0;
        reset     = 1'b0;
        model_clr = 1'b0;
        @(negedge clk);
        #1;
        check("gnt_idle", 256'(cpu_gnt_o), 256'(1));

        fetch(32'h0000_0414, 32'h0000_0000, 1'b1, 1'b0, 32'h2222_2222);
        fetch(32'h0000_0414, 32'h0000_0000, 1'b0, 1'b0, 32'h2222_2222);
        fetch(32'h0000_0810, 32'hA000_0000, 1'b1, 1'b1, 32'hB111_1111);
        fetch(32'h0000_0C10, 32'hB000_0000, 1'b1, 1'b0, 32'hA111_1111);
        fetch(32'h0000_0414, 32'h0C00_0000, 1'b1, 1'b1, 32'h2E22_2222);
        fetch(32'h0000_0C14, 32'h0000_0000, 1'b0, 1'b0, 32'h9222_2222);
        fetch(32'h0000_0410, 32'h0000_0000, 1'b0, 1'b1, 32'h1D11_1111);
        fetch(32'h0000_101C, 32'h0000_1000, 1'b1, 1'b0, 32'h4444_5444);

        // Flush wins over a same-cycle request.
        @(negedge clk);
        flush_i    = 1'b1;
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_0414;
        #1;
        check("gnt_during_flush_req", 256'(cpu_gnt_o), 256'(0));
        b0 = busy_cnt;
        w0 = fwr_cnt;
        @(negedge clk);
        flush_i   = 1'b0;
        cpu_req_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (!flush_busy_o) break;
        end
        check("flush_busy_cycles", 256'(busy_cnt - b0), 256'(128));
        check("flush_writes", 256'(fwr_cnt - w0), 256'(128));
        fetch(32'h0000_0414, 32'h0050_0000, 1'b1, 1'b0, 32'h2272_2222);

        gnt_stall = 5;
        fetch(32'h1234_5678, 32'h0000_00FF, 1'b1, 1'b0, 32'h3333_33CC);

        // Reset in the middle of a refill.
        @(negedge clk);
        mem_salt = 32'h0000_0030;
        for (int b = 0; b < 4; b++) exp_addr_q.push_back({28'h000_0200, 2'(b), 2'b00});
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_2000;
        #1;
        check("cpu_gnt_rst_test", 256'(cpu_gnt_o), 256'(1));
        @(negedge clk);
        cpu_req_i = 1'b0;
        r0 = rv_cnt;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (rv_cnt - r0 >= 2) break;
        end
        check("beats_before_reset", 256'(rv_cnt - r0), 256'(2));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_mid_refill_outputs", 256'(outs()), 256'(RST_OUTS));
        @(negedge clk);
        reset = 1'b0;
        exp_addr_q.delete();
        repeat (10) @(negedge clk);
        #1;
        check("idle_after_reset", 256'({cpu_gnt_o, mem_req_o, flush_busy_o}), 256'(3'b100));
        fetch(32'h0000_2000, 32'h0000_0030, 1'b1, 1'b0, 32'h1111_1121);

        repeat (5) @(negedge clk);
        check("queues_empty", 256'(exp_addr_q.size() + fill_q.size() + rsp_data_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
